// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM encoding and op-class helpers for the multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MADD  = 4'd4;
  localparam logic [3:0] MDU_MADDU = 4'd5;
  localparam logic [3:0] MDU_MSUB  = 4'd6;
  localparam logic [3:0] MDU_MSUBU = 4'd7;
  localparam logic [3:0] MDU_MTHI  = 4'd8;
  localparam logic [3:0] MDU_MTLO  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } mdu_state_e;

  // Ops 0-7 take the iterative path; the even ones are the signed variants.
  function automatic logic is_iter_op(input logic [3:0] op);
    return op <= MDU_MSUBU;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op <= MDU_MSUBU) && !op[0];
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_hi;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  // Multiply: acc = {partial product, remaining multiplier bits}; add multiplicand when LSB set.
  // Divide: acc = {remainder, dividend/quotient bits}; quotient bits shift in at the bottom.
  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    mul_hi  = acc_i[0] ? mul_sum : {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, opnd_i};
    // Remainder stays below the divisor, so the difference always fits in WIDTH bits.
    rem_sub = WIDTH'(rem_sh - {1'b0, opnd_i});
    if (div_i) begin
      acc_o = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], rem_ge};
    end else begin
      acc_o = {mul_hi, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [3:0]           op_q, op_d;
  logic                 s_a_q, s_a_d, s_b_q, s_b_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0]   prod, fix_hilo;
  logic                 fix_dbz;

  mdu_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .div_i (is_div_op(op_q)),
    .acc_i (acc_q),
    .opnd_i(opnd_q),
    .acc_o (acc_step)
  );

  // Operand magnitudes for signed ops; the iteration itself is always unsigned.
  always_comb begin
    mag_a = (is_signed_op(Op) && A[WIDTH-1]) ? -A : A;
    mag_b = (is_signed_op(Op) && B[WIDTH-1]) ? -B : B;
  end

  // Sign fix-up and HI/LO accumulate applied in the FIX cycle.
  always_comb begin
    prod    = (s_a_q ^ s_b_q) ? -acc_q : acc_q;
    quo     = (s_a_q ^ s_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = s_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // Divide by zero leaves |A| as remainder, so the sign fix restores the original A.
    fix_dbz = is_div_op(op_q) && (opnd_q == '0);
    unique case (op_q)
      MDU_DIV, MDU_DIVU:   fix_hilo = {rem, (fix_dbz ? {WIDTH{1'b1}} : quo)};
      MDU_MADD, MDU_MADDU: fix_hilo = {hi_q, lo_q} + prod;
      MDU_MSUB, MDU_MSUBU: fix_hilo = {hi_q, lo_q} - prod;
      default:             fix_hilo = prod;
    endcase
  end

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    s_a_d   = s_a_q;
    s_b_d   = s_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          if (is_iter_op(Op)) begin
            op_d    = Op;
            s_a_d   = is_signed_op(Op) && A[WIDTH-1];
            s_b_d   = is_signed_op(Op) && B[WIDTH-1];
            acc_d   = {{WIDTH{1'b0}}, (is_div_op(Op) ? mag_a : mag_b)};
            opnd_d  = is_div_op(Op) ? mag_b : mag_a;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_CALC;
          end else begin
            if (Op == MDU_MTHI) hi_d = A;
            if (Op == MDU_MTLO) lo_d = A;
            done_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Abort) begin
          {hi_d, lo_d} = fix_hilo;
          done_d       = 1'b1;
          dbz_d        = fix_dbz;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      s_a_q   <= 1'b0;
      s_b_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      s_a_q   <= s_a_d;
      s_b_q   <= s_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers. It is the sequential successor to the single-cycle ALU32Bit.
- Sits beside the ALU in the EX stage. The pipeline issues an op with Start, stalls while Busy is high, and reads HI/LO after Done.
- Supports signed and unsigned mult, div, madd and msub, plus mthi/mtlo. Result width and iteration count scale with WIDTH.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset.
- Start  in  1  issue request; sampled only in IDLE.
- Op  in  4  operation code (see Behaviour).
- A  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  in  WIDTH  rt operand (divisor / multiplier).
- Abort  in  1  pipeline flush: cancels the in-flight op.
- Busy  out  1  high while an iterative op is in flight.
- Done  out  1  one-cycle pulse when HI/LO have been updated.
- DivByZero  out  1  sticky for the Done cycle of a div/divu with B==0.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset (Rst==0 at an edge): state=IDLE; HI=LO=0; Busy=Done=DivByZero=0; counter=0. Reset mid-operation discards the op and leaves HI/LO=0.
- Op codes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
  - 8 MTHI, 9 MTLO
  - 10-15 no-op
- States: IDLE, CALC, FIX.
- IDLE, Start=1 at edge E0:
  - Iterative op (0-7): latch operands as magnitudes for signed ops, plus the sign bits. Go to CALC with counter=WIDTH. Busy=1 from E0.
  - MTHI/MTLO: write HI (or LO) = A at E0; Done=1 for the following cycle; Busy stays 0.
  - No-op: Done=1 for one cycle; HI/LO unchanged.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add over a 2*WIDTH product.
  - Divide: restoring shift-subtract.
  - Counter decrements each step; when it reaches 0, go to FIX.
- FIX (exactly 1 cycle). HI/LO are written at the FIX edge E(WIDTH+1); Busy drops; Done=1 for the next cycle; return to IDLE.
  - Signed mult: negate the 2*WIDTH product if sA^sB.
  - Signed div: quotient sign = sA^sB; remainder sign = sA.
  - MADD/MSUB: {HI,LO} = {HI,LO} ± product, mod 2^(2*WIDTH).
  - Div results: LO=quotient, HI=remainder.
- Latency: Done is visible WIDTH+1 clocks after the Start edge for ops 0-7, and 1 clock after it for ops 8-15.
- Start while Busy=1: ignored. The issuer must hold Start until Busy is seen (standard stall).
- Divide by zero:
  - Still takes the full WIDTH+1 cycles.
  - LO = all ones; HI = A (original signed A for DIV).
  - DivByZero=1 during the Done cycle only.
- Signed overflow, DIV of most-negative by -1: LO = most-negative, HI = 0, no flag.
- Abort=1 in CALC or FIX: return to IDLE at that edge; HI/LO unchanged; Busy=0; no Done.
- Abort in IDLE together with Start: Abort wins; nothing is issued.
- Back-to-back issue: Start may be accepted in the Done cycle, since the state is already IDLE. The new op reads the updated HI/LO for MADD/MSUB.

Decomposition:
- Shared package mdu_pkg holds:
  - the Op localparams (MDU_MULT..MDU_MTLO);
  - the state encoding (S_IDLE, S_CALC, S_FIX).
- One sub-module, mdu_datapath: the combinational single-step shift-add/shift-subtract for one iteration.
- mult_div_unit owns the FSM, counter, sign bookkeeping, fix-up and the HI/LO registers.

Test Plan (WIDTH=32):
- MULT A=-4, B=3: Busy high 33 cycles; Done pulse; {HI,LO}=64'hFFFFFFFF_FFFFFFF4. Then MULTU A=32'hFFFFFFFF, B=2 -> HI=1, LO=32'hFFFFFFFE.
- DIV A=-7, B=2 -> LO=-3, HI=-1. DIVU A=7, B=2 -> LO=3, HI=1. DIV A=32'h80000000, B=-1 -> LO=32'h80000000, HI=0.
- DIVU A=9, B=0 -> after 33 cycles LO=32'hFFFFFFFF, HI=9, DivByZero=1 for exactly the Done cycle.
- MTHI 5, MTLO 10, then MADD A=2, B=3 -> HI=5, LO=16. Then MSUB A=2, B=8 -> LO=0, HI=5. Done 1 cycle after each mt.
- MULT 5×7 issued, Abort at cycle 10 -> Busy drops; no Done; HI/LO keep their prior values. Start during Busy is ignored (result equals the first op's).
- Rst=0 asserted mid-DIV at cycle 20 -> next cycle HI=LO=0, Busy=0, Done=0. A new MULT 6×7 afterwards yields LO=42.
